pingpong_pixel_ram: RTL and testbench
=====================================

PINGPONG_PIXEL_RAM -- requirements
Module: pingpong_pixel_ram

Interface
REQ-001 Parameter SIZE, default 24, SHALL set the width of each stored word.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of words per bank; AW = $clog2(DEPTH); storage is 2*DEPTH words.
REQ-003 clk  in  1  SHALL be the single clock; all logic is on posedge clk.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 wr_addr  in  AW  SHALL be the write address within the back bank.
REQ-006 wr_data  in  SIZE  SHALL be the write data.
REQ-007 wr_en  in  1  SHALL be the write strobe, honoured only while wr_ready=1.
REQ-008 wr_frame_done  in  1  SHALL be a single-cycle pulse marking the back bank complete.
REQ-009 wr_ready  out  1  SHALL indicate that the back bank accepts writes and wr_frame_done.
REQ-010 rd_addr  in  AW  SHALL be the read address within the front bank.
REQ-011 rd_en  in  1  SHALL be the read strobe.
REQ-012 rd_data  out  SIZE  SHALL be the front-bank word read.
REQ-013 rd_valid  out  1  SHALL qualify rd_data.
REQ-014 rd_frame_done  in  1  SHALL be a single-cycle pulse marking the end of one reader scan.
REQ-015 frame_valid  out  1  SHALL indicate that the front bank holds a complete frame.

Function
REQ-016 The block SHALL hold a bank pointer wr_bank; the back bank = wr_bank and the front bank = ~wr_bank.
REQ-017 States: EMPTY (no front frame), SHOW (front frame readable, back bank writable), PENDING (back bank complete, waiting for the reader).
REQ-018 EMPTY: wr_frame_done SHALL toggle wr_bank and move to SHOW; rd_frame_done SHALL be ignored.
REQ-019 SHOW: wr_frame_done alone SHALL move to PENDING; rd_frame_done alone SHALL stay in SHOW so the same frame repeats.
REQ-020 SHOW: wr_frame_done and rd_frame_done in the same cycle SHALL toggle wr_bank and stay in SHOW.
REQ-021 PENDING: rd_frame_done SHALL toggle wr_bank and move to SHOW; wr_frame_done and wr_en SHALL be ignored.
REQ-022 wr_ready SHALL be 1 in EMPTY and SHOW and 0 in PENDING, decoded from the registered state.
REQ-023 frame_valid SHALL be 1 in SHOW and PENDING and 0 in EMPTY.
REQ-024 Write: when wr_en=1 and wr_ready=1, mem[{wr_bank,wr_addr}] SHALL take wr_data at the clock edge.
REQ-025 Read: when rd_en=1, rd_data SHALL take mem[{~wr_bank,rd_addr}] one cycle later, using the bank pointer in force at the rd_en cycle.
REQ-026 rd_valid SHALL equal the previous cycle's (rd_en AND frame_valid); rd_data SHALL hold its value when rd_en=0.
REQ-027 A swap cycle SHALL take effect for writes and reads from the next cycle; a read issued in the swap cycle returns old-front data.
REQ-028 The two ports SHALL never address the same bank, so no read/write collision exists.
REQ-029 An address at or above DEPTH (non-power-of-two DEPTH) SHALL not write and SHALL read an undefined value.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state=EMPTY, wr_bank=0, rd_data=0 and rd_valid=0, and SHALL clear overrun if present.
REQ-031 Reset SHALL NOT clear memory contents; reset mid-frame SHALL discard any pending or shown frame.

Configuration
REQ-032 With macro PINGPONG_PIXEL_RAM_OVERRUN_EN defined, output overrun (1 bit) SHALL set sticky when wr_frame_done arrives in PENDING, and SHALL clear only on reset.
REQ-033 Without PINGPONG_PIXEL_RAM_OVERRUN_EN, the overrun port and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-034 Reset, write 0x112233 @ addr 5, pulse wr_frame_done, rd_en @ addr 5 -> frame_valid=1; next cycle rd_data=0x112233, rd_valid=1.
REQ-035 In EMPTY, rd_en @ addr 0 -> rd_valid=0 next cycle; rd_frame_done -> state remains EMPTY.
REQ-036 SHOW, write back bank, pulse wr_frame_done -> wr_ready=0; wr_en of 0xFFFFFF @ 5 ignored; rd_frame_done -> swap, wr_ready=1, new data readable.
REQ-037 SHOW, wr_frame_done and rd_frame_done in the same cycle -> immediate swap, wr_ready stays 1.
REQ-038 PENDING, second wr_frame_done -> overrun=1 (with macro); rst_n low mid-PENDING -> EMPTY, wr_ready=1, overrun=0.

Source files
------------

// File: rtl/pingpong_pixel_ram.sv
// pingpong_pixel_ram
//   Double-buffered pixel frame store. A producer fills the back bank while a
//   consumer scans the front bank; the banks swap when a complete back frame
//   meets the end of a reader scan, or immediately if no frame is shown yet.
//   The bank pointer wr_bank selects the back bank; the front bank is ~wr_bank.
//
//   Optional feature macro: PINGPONG_PIXEL_RAM_OVERRUN_EN
//     When defined, adds a sticky 'overrun' output that sets if the producer
//     completes another frame while the previous one is still waiting to be
//     shown. Only reset clears it.

module pingpong_pixel_ram #(
  parameter  int SIZE  = 24,
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wr_addr,
  input  logic [SIZE-1:0] wr_data,
  input  logic            wr_en,
  input  logic            wr_frame_done,
  output logic            wr_ready,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_en,
  output logic [SIZE-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_frame_done,
  output logic            frame_valid
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
  ,
  output logic            overrun
`endif
);

  // Index width covering both banks of storage.
  localparam int IW = AW + 1;

  // EMPTY   : nothing shown yet, back bank is filling.
  // SHOW    : front frame readable, back bank writable.
  // PENDING : back bank complete, waiting for the reader to finish a scan.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_SHOW    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            wr_bank;
  logic            bank_toggle;

  logic [SIZE-1:0] mem [2*DEPTH];

  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            wr_in_range;
  logic            rd_in_range;
  logic            wr_accept;

  // Bank offsets are added rather than concatenated so that a non-power-of-two
  // DEPTH still packs both banks into exactly 2*DEPTH words; for power-of-two
  // DEPTH this is identical to {bank, addr}.
  always_comb begin
    wr_idx      = {1'b0, wr_addr} + (wr_bank  ? IW'(DEPTH) : {IW{1'b0}});
    rd_idx      = {1'b0, rd_addr} + (!wr_bank ? IW'(DEPTH) : {IW{1'b0}});
    wr_in_range = ({1'b0, wr_addr} < IW'(DEPTH));
    rd_in_range = ({1'b0, rd_addr} < IW'(DEPTH));
    wr_accept   = wr_en && wr_ready && wr_in_range;
  end

  // Next-state logic and state-decoded outputs; the bank pointer flips on
  // every transition that hands the completed back bank to the reader.
  always_comb begin
    state_nxt   = state;
    bank_toggle = 1'b0;
    wr_ready    = (state != ST_PENDING);
    frame_valid = (state != ST_EMPTY);
    case (state)
      ST_EMPTY: begin
        if (wr_frame_done) begin
          state_nxt   = ST_SHOW;
          bank_toggle = 1'b1;
        end
      end
      ST_SHOW: begin
        if (wr_frame_done && rd_frame_done) begin
          state_nxt   = ST_SHOW;
          bank_toggle = 1'b1;
        end else if (wr_frame_done) begin
          state_nxt   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (rd_frame_done) begin
          state_nxt   = ST_SHOW;
          bank_toggle = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_EMPTY;
      end
    endcase
  end

  // State and bank pointer registers; reset discards any shown or pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      wr_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bank_toggle) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Pixel storage write port into the back bank; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read from the front bank; data holds while no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && frame_valid;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_idx] : '0;
      end
    end
  end

`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
  // Sticky flag: producer finished another frame before the pending one was shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if ((state == ST_PENDING) && wr_frame_done) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_pixel_ram.sv
// tb_pingpong_pixel_ram
//   Directed scenarios followed by randomized traffic, all checked against a
//   frame-level reference model: two arrays of pixels, a "frame shown" flag
//   and a "back frame complete" flag.

module tb_pingpong_pixel_ram;

  localparam int SIZE  = 24;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;
  logic            wr_en;
  logic            wr_frame_done;
  logic            wr_ready;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [SIZE-1:0] rd_data;
  logic            rd_valid;
  logic            rd_frame_done;
  logic            frame_valid;
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
  logic            overrun;
`endif

  int checks;
  int errors;

  // Reference model
  logic [SIZE-1:0] m_mem   [2][DEPTH];
  bit              m_known [2][DEPTH];
  bit              m_bank;
  bit              m_have_front;
  bit              m_back_full;
  logic [SIZE-1:0] exp_rd_data;
  bit              exp_rd_known;
  bit              exp_rd_valid;
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
  bit              m_overrun;
`endif

  pingpong_pixel_ram #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_frame_done (wr_frame_done),
    .wr_ready      (wr_ready),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_frame_done (rd_frame_done),
    .frame_valid   (frame_valid)
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_bank       = 1'b0;
    m_have_front = 1'b0;
    m_back_full  = 1'b0;
    exp_rd_data  = '0;
    exp_rd_known = 1'b1;
    exp_rd_valid = 1'b0;
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
    m_overrun    = 1'b0;
`endif
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, return at edge+1
  task automatic do_cycle(input bit wen, input logic [AW-1:0] waddr,
                          input logic [SIZE-1:0] wdata, input bit wfd,
                          input bit ren, input logic [AW-1:0] raddr,
                          input bit rfd);
    bit front;
    wr_en         = wen;
    wr_addr       = waddr;
    wr_data       = wdata;
    wr_frame_done = wfd;
    rd_en         = ren;
    rd_addr       = raddr;
    rd_frame_done = rfd;
    @(posedge clk);
    front = ~m_bank;
    exp_rd_valid = ren && m_have_front;
    if (ren) begin
      exp_rd_data  = m_mem[front][raddr];
      exp_rd_known = m_known[front][raddr];
    end
    if (wen && !m_back_full) begin
      m_mem[m_bank][waddr]   = wdata;
      m_known[m_bank][waddr] = 1'b1;
    end
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
    if (wfd && m_back_full) m_overrun = 1'b1;
`endif
    if (!m_have_front) begin
      if (wfd) begin
        m_bank       = ~m_bank;
        m_have_front = 1'b1;
      end
    end else if (!m_back_full) begin
      if (wfd && rfd)  m_bank = ~m_bank;
      else if (wfd)    m_back_full = 1'b1;
    end else if (rfd) begin
      m_bank      = ~m_bank;
      m_back_full = 1'b0;
    end
    #1;
    wr_en         = 1'b0;
    wr_frame_done = 1'b0;
    rd_en         = 1'b0;
    rd_frame_done = 1'b0;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid actual=%b expected=0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("[TB] FAIL reset_rd_data actual=%h expected=0", rd_data); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready actual=%b expected=1", wr_ready); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_valid actual=%b expected=0", frame_valid); end
    release_reset();
  endtask

  task automatic test_basic();
    do_cycle(1'b1, 8'd5, 24'h112233, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_frame_valid actual=%b expected=1", frame_valid); end
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 8'd5, 1'b0);
    checks++; if (rd_data !== 24'h112233) begin errors++; $display("[TB] FAIL basic_rd_data actual=%h expected=112233", rd_data); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_rd_valid actual=%b expected=1", rd_valid); end
    idle_cycle();
    checks++; if (rd_data !== 24'h112233) begin errors++; $display("[TB] FAIL basic_rd_hold actual=%h expected=112233", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_rd_valid_drop actual=%b expected=0", rd_valid); end
  endtask

  task automatic test_show_pending();
    do_cycle(1'b1, 8'd5, 24'hABCDEF, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_wr_ready actual=%b expected=0", wr_ready); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL pend_frame_valid actual=%b expected=1", frame_valid); end
    do_cycle(1'b1, 8'd5, 24'hFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 8'd5, 1'b0);
    checks++; if (rd_data !== 24'h112233) begin errors++; $display("[TB] FAIL pend_old_front actual=%h expected=112233", rd_data); end
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL pend_swap_wr_ready actual=%b expected=1", wr_ready); end
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 8'd5, 1'b0);
    checks++; if (rd_data !== 24'hABCDEF) begin errors++; $display("[TB] FAIL pend_new_front actual=%h expected=abcdef", rd_data); end
  endtask

  task automatic test_simultaneous();
    do_cycle(1'b1, 8'd7, 24'h445566, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b1, 8'd5, 1'b1);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL simul_wr_ready actual=%b expected=1", wr_ready); end
    checks++; if (rd_data !== 24'hABCDEF) begin errors++; $display("[TB] FAIL simul_swap_read actual=%h expected=abcdef", rd_data); end
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 8'd7, 1'b0);
    checks++; if (rd_data !== 24'h445566) begin errors++; $display("[TB] FAIL simul_new_front actual=%h expected=445566", rd_data); end
  endtask

  task automatic test_empty();
    assert_reset();
    release_reset();
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 8'd0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_rd_valid actual=%b expected=0", rd_valid); end
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_stays actual=%b expected=0", frame_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL empty_wr_ready actual=%b expected=1", wr_ready); end
  endtask

  task automatic test_overrun_reset();
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovr_pending actual=%b expected=0", wr_ready); end
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set actual=%b expected=1", overrun); end
`endif
    assert_reset();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_frame_valid actual=%b expected=0", frame_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_wr_ready actual=%b expected=1", wr_ready); end
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overrun actual=%b expected=0", overrun); end
`endif
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
               SIZE'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
               $urandom_range(0, 5) == 0);
      checks++; if (rd_valid !== exp_rd_valid) begin errors++; $display("[TB] FAIL rand_rd_valid cycle=%0d actual=%b expected=%b", i, rd_valid, exp_rd_valid); end
      checks++; if (wr_ready !== !m_back_full) begin errors++; $display("[TB] FAIL rand_wr_ready cycle=%0d actual=%b expected=%b", i, wr_ready, !m_back_full); end
      checks++; if (frame_valid !== m_have_front) begin errors++; $display("[TB] FAIL rand_frame_valid cycle=%0d actual=%b expected=%b", i, frame_valid, m_have_front); end
      if (exp_rd_known) begin
        checks++; if (rd_data !== exp_rd_data) begin errors++; $display("[TB] FAIL rand_rd_data cycle=%0d actual=%h expected=%h", i, rd_data, exp_rd_data); end
      end
`ifdef PINGPONG_PIXEL_RAM_OVERRUN_EN
      checks++; if (overrun !== m_overrun) begin errors++; $display("[TB] FAIL rand_overrun cycle=%0d actual=%b expected=%b", i, overrun, m_overrun); end
`endif
    end
  endtask

  // Scenario sequence
  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_frame_done = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    rd_frame_done = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        m_mem[b][a]   = '0;
        m_known[b][a] = 1'b0;
      end
    end
    model_reset();
    #1;
    $display("[TB] starting");
    test_reset();
    test_basic();
    test_show_pending();
    test_simultaneous();
    test_empty();
    test_overrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
